// File: rtl/fifo_thresh_if.sv
// Handshake/status bundle for one fifo_thresh channel.
// The master side is the producer/consumer logic; the slave side is the FIFO itself.
interface fifo_thresh_if #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
);
  logic [DATA_BITS-1:0] fifo_data_in;
  logic                 fifo_write;
  logic                 fifo_read;
  logic [ADDR_BITS:0]   high_limit;
  logic [ADDR_BITS:0]   low_limit;
  logic                 err_clear;
  logic [DATA_BITS-1:0] fifo_data_out;
  logic                 fifo_valid_out;
  logic                 fifo_full_out;
  logic                 fifo_empty_out;
  logic                 almost_full_out;
  logic                 almost_empty_out;
  logic [ADDR_BITS:0]   fifo_count_out;
  logic                 overflow_err_out;
  logic                 underflow_err_out;
  logic [ADDR_BITS:0]   fifo_peak_out;

  modport master (
    output fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, err_clear,
    input  fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
           almost_full_out, almost_empty_out, fifo_count_out,
           overflow_err_out, underflow_err_out, fifo_peak_out
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, err_clear,
    output fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
           almost_full_out, almost_empty_out, fifo_count_out,
           overflow_err_out, underflow_err_out, fifo_peak_out
  );
endinterface

// File: rtl/fifo_thresh.sv
// Single-clock FIFO with occupancy count, programmable thresholds, sticky errors and registered read.
// Define FIFO_THRESH_PEAK_EN to build the peak-occupancy register behind fifo_peak_out.
module fifo_thresh #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input logic          clk,
  input logic          reset,
  fifo_thresh_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_BITS:0]   count_reg, count_next;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 valid_reg;
  logic                 ovf_reg, ovf_next;
  logic                 unf_reg, unf_next;
  logic                 rd_acc, wr_acc;
  logic [ADDR_BITS:0]   high_sat, low_sat;

  // Acceptance is judged on the registered count; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    rd_acc     = bus.fifo_read && (count_reg != '0);
    wr_acc     = bus.fifo_write && ((count_reg != DEPTH_C) || rd_acc);
    count_next = count_reg;
    if (wr_acc && !rd_acc)
      count_next = count_reg + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_next = count_reg - CNT_ONE;
    // A new error on the clearing edge keeps the flag set.
    ovf_next = (bus.fifo_write && !wr_acc) || (ovf_reg && !bus.err_clear);
    unf_next = (bus.fifo_read && !rd_acc) || (unf_reg && !bus.err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      valid_reg <= rd_acc;
      if (wr_acc)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr_reg] <= bus.fifo_data_in;
  end

  always_comb begin
    high_sat = (bus.high_limit > DEPTH_C) ? DEPTH_C : bus.high_limit;
    low_sat  = (bus.low_limit > DEPTH_C) ? DEPTH_C : bus.low_limit;
  end

  assign bus.fifo_data_out     = data_out_reg;
  assign bus.fifo_valid_out    = valid_reg;
  assign bus.fifo_count_out    = count_reg;
  assign bus.fifo_full_out     = (count_reg == DEPTH_C);
  assign bus.fifo_empty_out    = (count_reg == '0);
  assign bus.almost_full_out   = (bus.high_limit == '0) ? (count_reg == DEPTH_C)
                                                        : (count_reg >= high_sat);
  assign bus.almost_empty_out  = (count_reg <= low_sat);
  assign bus.overflow_err_out  = ovf_reg;
  assign bus.underflow_err_out = unf_reg;

`ifdef FIFO_THRESH_PEAK_EN
  logic [ADDR_BITS:0] peak_reg, peak_next;

  always_comb begin
    peak_next = peak_reg;
    if (bus.err_clear || (count_next > peak_reg))
      peak_next = count_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      peak_reg <= '0;
    else
      peak_reg <= peak_next;
  end

  assign bus.fifo_peak_out = peak_reg;
`else
  assign bus.fifo_peak_out = '0;
`endif
endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh (DATA_BITS=10, ADDR_BITS=3): vector table plus hand sequences
// for pointer wrap and asynchronous reset.
module tb_fifo_thresh;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_thresh_if #(.DATA_BITS(10), .ADDR_BITS(3)) bus ();
  fifo_thresh #(.DATA_BITS(10), .ADDR_BITS(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  // flg = {full, empty, almost_full, almost_empty}
  typedef struct {
    logic       wr, rd, clr;
    logic [9:0] din;
    logic [3:0] hi, lo;
    logic [3:0] cnt;
    logic       vld;
    logic [9:0] dout;
    logic       ovf, unf;
    logic [3:0] flg;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [9:0] din,
                              logic [3:0] hi, logic [3:0] lo, logic [3:0] cnt,
                              logic vld, logic [9:0] dout, logic ovf, logic unf,
                              logic [3:0] flg);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.hi = hi; v.lo = lo;
    v.cnt = cnt; v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.fifo_full_out, bus.fifo_empty_out, bus.almost_full_out, bus.almost_empty_out};
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic clr, input logic [9:0] din);
    bus.fifo_write   = wr;
    bus.fifo_read    = rd;
    bus.err_clear    = clr;
    bus.fifo_data_in = din;
  endtask

  task automatic op(input logic wr, input logic rd, input logic clr, input logic [9:0] din);
    drive(wr, rd, clr, din);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 10'h000);
    $display("op wr=%b rd=%b clr=%b din=%h -> cnt=%0d vld=%b dout=%h ovf=%b unf=%b",
             wr, rd, clr, din, bus.fifo_count_out, bus.fifo_valid_out,
             bus.fifo_data_out, bus.overflow_err_out, bus.underflow_err_out);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 10'h000);
    bus.high_limit = 4'd6;
    bus.low_limit  = 4'd2;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(bus.fifo_count_out), 32'd0);
    chk("rst_flags", 32'(flags()), 32'b0101);
    chk("rst_valid", 32'(bus.fifo_valid_out), 32'd0);
    chk("rst_dout", 32'(bus.fifo_data_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err_out), 32'd0);
    chk("rst_unf", 32'(bus.underflow_err_out), 32'd0);
    chk("rst_peak", 32'(bus.fifo_peak_out), 32'd0);

    //             wr   rd   clr  din    hi lo cnt vld dout  ovf unf flg
    // Fill, overflow, drain, underflow (hi=6, lo=2)
    vq.push_back(mk(1,  0,   0,   10'h001, 6, 2, 1, 0, 10'h0, 0, 0, 4'b0001));
    vq.push_back(mk(1,  0,   0,   10'h002, 6, 2, 2, 0, 10'h0, 0, 0, 4'b0001));
    vq.push_back(mk(1,  0,   0,   10'h003, 6, 2, 3, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h004, 6, 2, 4, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h005, 6, 2, 5, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h006, 6, 2, 6, 0, 10'h0, 0, 0, 4'b0010));
    vq.push_back(mk(1,  0,   0,   10'h007, 6, 2, 7, 0, 10'h0, 0, 0, 4'b0010));
    vq.push_back(mk(1,  0,   0,   10'h008, 6, 2, 8, 0, 10'h0, 0, 0, 4'b1010));
    vq.push_back(mk(1,  0,   0,   10'h0FF, 6, 2, 8, 0, 10'h0, 1, 0, 4'b1010));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 7, 1, 10'h001, 1, 0, 4'b0010));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 6, 1, 10'h002, 1, 0, 4'b0010));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 5, 1, 10'h003, 1, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 4, 1, 10'h004, 1, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 3, 1, 10'h005, 1, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 2, 1, 10'h006, 1, 0, 4'b0001));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 1, 1, 10'h007, 1, 0, 4'b0001));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 0, 1, 10'h008, 1, 0, 4'b0101));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 0, 0, 10'h0, 1, 1, 4'b0101));
    vq.push_back(mk(0,  0,   1,   10'h000, 6, 2, 0, 0, 10'h0, 0, 0, 4'b0101));
    // Simultaneous push/pop on empty: pop dropped, no bypass
    vq.push_back(mk(1,  1,   0,   10'h0AA, 6, 2, 1, 0, 10'h0, 0, 1, 4'b0001));
    vq.push_back(mk(0,  1,   0,   10'h000, 6, 2, 0, 1, 10'h0AA, 0, 1, 4'b0101));
    vq.push_back(mk(0,  0,   1,   10'h000, 6, 2, 0, 0, 10'h0, 0, 0, 4'b0101));
    // hi=0: almost_full follows full only
    vq.push_back(mk(1,  0,   0,   10'h010, 0, 2, 1, 0, 10'h0, 0, 0, 4'b0001));
    vq.push_back(mk(1,  0,   0,   10'h011, 0, 2, 2, 0, 10'h0, 0, 0, 4'b0001));
    vq.push_back(mk(1,  0,   0,   10'h012, 0, 2, 3, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h013, 0, 2, 4, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h014, 0, 2, 5, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h015, 0, 2, 6, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h016, 0, 2, 7, 0, 10'h0, 0, 0, 4'b0000));
    vq.push_back(mk(1,  0,   0,   10'h017, 0, 2, 8, 0, 10'h0, 0, 0, 4'b1010));
    // Simultaneous push/pop on full: both accepted, no overflow
    vq.push_back(mk(1,  1,   0,   10'h018, 0, 2, 8, 1, 10'h010, 0, 0, 4'b1010));
    // Clear together with a fresh overflow: error wins
    vq.push_back(mk(1,  0,   1,   10'h0EE, 0, 2, 8, 0, 10'h0, 1, 0, 4'b1010));
    vq.push_back(mk(0,  0,   1,   10'h000, 0, 2, 8, 0, 10'h0, 0, 0, 4'b1010));
    // hi=12 saturates to DEPTH; lo=0 makes almost_empty equal empty
    vq.push_back(mk(0,  0,   0,   10'h000, 12, 0, 8, 0, 10'h0, 0, 0, 4'b1010));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 7, 1, 10'h011, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 6, 1, 10'h012, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 5, 1, 10'h013, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 4, 1, 10'h014, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 3, 1, 10'h015, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 2, 1, 10'h016, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 1, 1, 10'h017, 0, 0, 4'b0000));
    vq.push_back(mk(0,  1,   0,   10'h000, 12, 0, 0, 1, 10'h018, 0, 0, 4'b0101));

    foreach (vq[i]) begin
      bus.high_limit = vq[i].hi;
      bus.low_limit  = vq[i].lo;
      op(vq[i].wr, vq[i].rd, vq[i].clr, vq[i].din);
      chk($sformatf("v%0d_count", i), 32'(bus.fifo_count_out), 32'(vq[i].cnt));
      chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(vq[i].flg));
      chk($sformatf("v%0d_valid", i), 32'(bus.fifo_valid_out), 32'(vq[i].vld));
      if (vq[i].vld)
        chk($sformatf("v%0d_dout", i), 32'(bus.fifo_data_out), 32'(vq[i].dout));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow_err_out), 32'(vq[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(bus.underflow_err_out), 32'(vq[i].unf));
    end

    // Pointer wrap: 5 in/5 out then 6 in/6 out
    bus.high_limit = 4'd6;
    bus.low_limit  = 4'd2;
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 10'(10'h100 + i));
    chk("wrap_cnt5", 32'(bus.fifo_count_out), 32'd5);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 1'b0, 10'h000);
      chk($sformatf("wrap_a%0d", i), 32'({bus.fifo_valid_out, bus.fifo_data_out}),
          32'({1'b1, 10'(10'h100 + i)}));
    end
    for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 1'b0, 10'(10'h110 + i));
    chk("wrap_cnt6", 32'(bus.fifo_count_out), 32'd6);
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 1'b1, 1'b0, 10'h000);
      chk($sformatf("wrap_b%0d", i), 32'({bus.fifo_valid_out, bus.fifo_data_out}),
          32'({1'b1, 10'(10'h110 + i)}));
    end
    chk("wrap_cnt0", 32'(bus.fifo_count_out), 32'd0);

    // Async reset mid-burst at count=5 with an error pending
    op(1'b0, 1'b0, 1'b1, 10'h000);
    op(1'b0, 1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 10'(10'h1A0 + i));
    op(1'b1, 1'b1, 1'b0, 10'h1A5);
    chk("pre_count", 32'(bus.fifo_count_out), 32'd5);
    chk("pre_valid", 32'({bus.fifo_valid_out, bus.fifo_data_out}), 32'({1'b1, 10'h1A0}));
    chk("pre_unf", 32'(bus.underflow_err_out), 32'd1);
`ifdef FIFO_THRESH_PEAK_EN
    chk("pre_peak", 32'(bus.fifo_peak_out), 32'd5);
`else
    chk("pre_peak", 32'(bus.fifo_peak_out), 32'd0);
`endif
    #2 reset = 1'b1;
    #1;
    $display("async reset asserted between edges -> cnt=%0d vld=%b dout=%h",
             bus.fifo_count_out, bus.fifo_valid_out, bus.fifo_data_out);
    chk("ar_count", 32'(bus.fifo_count_out), 32'd0);
    chk("ar_flags", 32'(flags()), 32'b0101);
    chk("ar_valid", 32'(bus.fifo_valid_out), 32'd0);
    chk("ar_dout", 32'(bus.fifo_data_out), 32'd0);
    chk("ar_unf", 32'(bus.underflow_err_out), 32'd0);
    chk("ar_ovf", 32'(bus.overflow_err_out), 32'd0);
    chk("ar_peak", 32'(bus.fifo_peak_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset sees an empty FIFO; stale words are gone
    op(1'b0, 1'b1, 1'b0, 10'h000);
    chk("post_pop_valid", 32'(bus.fifo_valid_out), 32'd0);
    chk("post_pop_unf", 32'(bus.underflow_err_out), 32'd1);
    chk("post_pop_cnt", 32'(bus.fifo_count_out), 32'd0);
    op(1'b1, 1'b0, 1'b0, 10'h055);
    chk("post_wr_cnt", 32'(bus.fifo_count_out), 32'd1);
    op(1'b0, 1'b1, 1'b0, 10'h000);
    chk("post_rd", 32'({bus.fifo_valid_out, bus.fifo_data_out}), 32'({1'b1, 10'h055}));
    op(1'b0, 1'b0, 1'b0, 10'h000);
    chk("post_idle_valid", 32'(bus.fifo_valid_out), 32'd0);
    chk("post_idle_dout", 32'(bus.fifo_data_out), 32'h055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_thresh.md
Name: fifo_thresh

Overview:
Parametrised synchronous FIFO, the next generation of the project's single-clock FIFO. It adds the following over the previous generation:
- explicit occupancy counter,
- full-width programmable almost-full/almost-empty thresholds,
- separate sticky overflow/underflow flags with software clear,
- guarded push/pop (illegal operations are dropped, not executed),
- a registered read port with a valid strobe.

It sits between packet-producing logic and the downstream arbiter/demux, one instance per channel.

Parameters:
DATA_BITS, 10, word width in bits
ADDR_BITS, 3, log2 of depth; DEPTH = 2**ADDR_BITS entries

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
fifo_data_in  input  DATA_BITS  write data
fifo_write  input  1  push request
fifo_read  input  1  pop request
high_limit  input  ADDR_BITS+1  almost-full threshold (entries)
low_limit  input  ADDR_BITS+1  almost-empty threshold (entries)
err_clear  input  1  clears sticky error flags (and peak, see option)
fifo_data_out  output  DATA_BITS  registered read data
fifo_valid_out  output  1  fifo_data_out carries a freshly popped word
fifo_full_out  output  1  count == DEPTH
fifo_empty_out  output  1  count == 0
almost_full_out  output  1  threshold flag
almost_empty_out  output  1  threshold flag
fifo_count_out  output  ADDR_BITS+1  current occupancy 0..DEPTH
overflow_err_out  output  1  sticky: push dropped
underflow_err_out  output  1  sticky: pop dropped
fifo_peak_out  output  ADDR_BITS+1  max occupancy (optional feature)

Behaviour:
- Reset (asynchronous, takes effect immediately, regardless of clk):
  - write/read pointers, count, fifo_data_out, fifo_valid_out, both error flags and peak go to 0.
  - Storage array is not reset.
  - Reset asserted mid-burst discards all contents; first edge after deassertion behaves as an empty FIFO.
- Accept rules, evaluated on the registered count at the clock edge:
  - rd_acc = fifo_read && count != 0.
  - wr_acc = fifo_write && (count != DEPTH || rd_acc).
- Full + simultaneous read/write: both accepted, count unchanged, pointers both advance.
- Empty + simultaneous read/write: read dropped (underflow_err_out set), write accepted, count becomes 1. No bypass of write data to output.
- Write when full without read: data dropped, pointers/count unchanged, overflow_err_out set next edge.
- Read when empty: pointers/count unchanged, fifo_valid_out stays 0, underflow_err_out set next edge.
- Pointers are ADDR_BITS wide and wrap modulo DEPTH with no special handling. Count is ADDR_BITS+1 wide: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise.
- Read latency is 1 cycle. On rd_acc, at the same edge:
  - fifo_data_out <= mem[rd_ptr];
  - fifo_valid_out <= 1.
  Otherwise fifo_valid_out <= 0 and fifo_data_out holds its last value.
- Write: on wr_acc, mem[wr_ptr] <= fifo_data_in. A word written at edge N is readable by a pop at edge N+1 or later.
- Status flags are combinational from the registered count (no added latency): full, empty, almost_full, almost_empty, count.
  - Limits above DEPTH saturate to DEPTH.
  - almost_full_out = (high_limit == 0) ? full : (count >= high_limit).
  - almost_empty_out = (count <= low_limit). low_limit == 0 makes it equal to empty.
- Error flags:
  - Sticky until err_clear or reset.
  - If err_clear and a new error event occur on the same edge, the flag is set (error wins).

Optional Feature:
FIFO_THRESH_PEAK_EN:
- Defined: fifo_peak_out is a register tracking the maximum next-state count since reset or the last err_clear. On err_clear it loads the current next-state count. It updates on the same edge as count.
- Undefined: port remains present and is tied to 0; no peak register is synthesised.

Test Plan:
- ADDR_BITS=3: reset, write 8 words 0x001..0x008 -> count 8, full=1, empty=0, no errors; 9th write dropped -> overflow_err_out=1, count stays 8.
- From full: 8 pops -> fifo_valid_out pulses each cycle one edge after each pop, data 0x001..0x008 in order; then pop on empty -> underflow_err_out=1, valid=0.
- Wrap: 5 writes, 5 reads, 6 writes, 6 reads -> data order preserved across pointer wrap, count returns to 0.
- Simultaneous read/write at count=8 -> count stays 8, no overflow. At count=0 -> count 1, underflow=1, valid=0.
- high_limit=6, low_limit=2: fill 0..8 -> almost_empty=1 for count<=2, almost_full=1 for count>=6. high_limit=0 -> almost_full tracks full only.
- Assert reset asynchronously mid-burst (between edges) at count=5 with error set -> all outputs 0 immediately. err_clear together with a new overflow -> flag stays 1. With FIFO_THRESH_PEAK_EN defined, peak=5 before reset and 0 after.
